// File: rtl/fp_expander.sv
// rtl/fp_expander.sv - expands 8-bit {S,E,F} float to a 12-bit two's-complement word
//
// Purpose: decoder counterpart of the FPCVT compressor. Value = (-1)^S * F * 2^E.
//   The magnitude is built by shifting F left once per clock, E times, then the
//   sign is applied and the result is offered on a valid/ready output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready high only in IDLE)
//   S, E, F               sign, exponent, significand
//   out_valid / out_ready output handshake (out_valid high only in DONE)
//   D                     expanded result, held after the output handshake
module fp_expander #(
  parameter int W_D = 12,
  parameter int W_E = 3,
  parameter int W_F = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [W_E-1:0] E,
  input  logic [W_F-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_D-1:0] D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [W_D-1:0] mag;
  logic [W_E-1:0] cnt;
  logic           sgn;

  // in_ready and out_valid are registered alongside the state so that they
  // track IDLE and DONE exactly without any combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      D         <= '0;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag      <= {{(W_D-W_F){1'b0}}, F};
            cnt      <= E;
            sgn      <= S;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // The exit test is made before shifting, so E=0 still spends one cycle here.
          if (cnt == '0) begin
            state <= SIGN;
          end else begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
          end
        end
        SIGN: begin
          // Negating zero gives zero, so a negative-zero input yields D=0.
          D         <= sgn ? (~mag + 1'b1) : mag;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_expander.sv
// tb/tb_fp_expander.sv - directed scoreboard bench for fp_expander
module tb_fp_expander;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  int          lat_q[$];

  fp_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Present one input word and complete the accept edge; expected result is queued.
  task automatic start(input logic s, input logic [2:0] e, input logic [3:0] f,
                       input logic [11:0] exp_d);
    int w;
    @(negedge clk);
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    S = s;
    E = e;
    F = f;
    exp_q.push_back(exp_d);
    lat_q.push_back(int'(e) + 2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    S = ~s;
    E = ~e;
    F = ~f;
    check("in_ready_after_accept", in_ready, 1'b0);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard, optionally hold off.
  task automatic finish(input string tag, input int hold);
    int lat;
    logic [11:0] expd;
    int expl;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    expd = exp_q.pop_front();
    expl = lat_q.pop_front();
    check({tag, "_latency"}, lat, expl);
    check({tag, "_D"}, D, expd);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      S = 1'b0;
      E = 3'd1;
      F = 4'd3;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_out_valid"}, out_valid, 1'b1);
      check({tag, "_hold_D"}, D, expd);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 1'b0);
    check({tag, "_D_kept"}, D, expd);
    check({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    S = 1'b0;
    E = '0;
    F = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_D", D, 12'h000);
    rst_n = 1'b1;

    // 1: basic positive, latency E+2
    start(1'b0, 3'd2, 4'b1011, 12'h02C);
    finish("t1", 0);

    // 2: E=0 cases, including negative zero
    start(1'b1, 3'd0, 4'b0001, 12'hFFF);
    finish("t2_neg1", 0);
    start(1'b1, 3'd0, 4'b0000, 12'h000);
    finish("t2_negzero", 0);

    // 3: maximum magnitude both signs
    start(1'b0, 3'd7, 4'b1111, 12'h780);
    finish("t3_pos_max", 0);
    start(1'b1, 3'd7, 4'b1111, 12'h880);
    finish("t3_neg_max", 0);

    // 4: backpressure with ignored in_valid pulses
    start(1'b0, 3'd3, 4'b0101, 12'h028);
    finish("t4_bp", 5);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("t4_nothing_queued", out_valid, 1'b0);
    end

    // 5: reset during SHIFT aborts the operation
    start(1'b0, 3'd6, 4'b0001, 12'h040);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_D", D, 12'h000);
    check("t5_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("t5_no_stale_output", out_valid, 1'b0);
    end
    start(1'b0, 3'd1, 4'b1000, 12'h010);
    finish("t5_after_rst", 0);

    // 6: round-trip words from the compressor
    start(1'b0, 3'd4, 4'b1000, 12'h080);
    finish("t6_07D", 0);
    start(1'b0, 3'd2, 4'b1011, 12'h02C);
    finish("t6_02C", 0);
    start(1'b1, 3'd0, 4'b0001, 12'hFFF);
    finish("t6_FFF", 1);

    // extra mid-range negatives across exponents
    for (int e = 1; e < 7; e += 2) begin
      start(1'b1, 3'(e), 4'b0110, 12'(-(6 << e)));
      finish("sweep_neg", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
